// File: rtl/rvj1_load_scoreboard.sv
// ---------------------------------------------------------------------------
// rvj1_load_scoreboard
//
// Tracks the destination registers of outstanding loads in an in-order FIFO
// and holds the decoder while a candidate instruction would read or overwrite
// a register that a pending load has not yet written, or would issue a load
// while the FIFO is full. Loads complete in order, so the LSU only signals
// "oldest one done" and the head entry is retired.
//
// Ports
//   clk_i            clock, all state updates on the rising edge
//   rst_i            asynchronous active-high reset
//   issue_valid_i    decoded candidate present this cycle
//   issue_rs1_i      source register A,  issue_rs1_used_i  candidate reads it
//   issue_rs2_i      source register B,  issue_rs2_used_i  candidate reads it
//   issue_rd_i       destination,        issue_rd_used_i   candidate writes it
//   issue_is_load_i  candidate is a load
//   lsu_done_i       oldest outstanding load has written the register file
//   stall_o          hold the decoder
//   issue_fire_o     candidate accepted this cycle
//   pending_cnt_o    number of outstanding loads
//   underflow_o      sticky: lsu_done_i seen with nothing outstanding
// ---------------------------------------------------------------------------
module rvj1_load_scoreboard #(
  parameter int LOAD_DEPTH = 2   // legal 1..4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       issue_valid_i,
  input  logic [4:0] issue_rs1_i,
  input  logic       issue_rs1_used_i,
  input  logic [4:0] issue_rs2_i,
  input  logic       issue_rs2_used_i,
  input  logic [4:0] issue_rd_i,
  input  logic       issue_rd_used_i,
  input  logic       issue_is_load_i,
  input  logic       lsu_done_i,
  output logic       stall_o,
  output logic       issue_fire_o,
  output logic [2:0] pending_cnt_o,
  output logic       underflow_o
);

  // Pointers are sized for the largest legal depth so LOAD_DEPTH == 1 still
  // has a non-zero-width pointer; wrap is explicit, not by overflow.
  localparam int              PTR_W    = 2;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(LOAD_DEPTH - 1);
  localparam logic [2:0]       FULL_CNT = 3'(LOAD_DEPTH);

  logic [4:0]            ent_rd [LOAD_DEPTH];
  logic [LOAD_DEPTH-1:0] ent_vld;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr;
  logic [2:0]            count;
  logic                  underflow;

  logic raw_hit;
  logic waw_hit;
  logic struct_hit;
  logic push;
  logic pop;
  logic underflow_evt;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // Hazard detection looks only at registered FIFO state: a load retiring
  // this cycle still blocks its consumer, which is released next cycle.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the block leaves it unassigned and infers a latch.
    raw_hit = 1'b0;
    waw_hit = 1'b0;
    for (int i = 0; i < LOAD_DEPTH; i++) begin
      // An entry for x0 (kept only to preserve completion order) never matches.
      if (ent_vld[i] && (ent_rd[i] != 5'd0)) begin
        if (issue_rs1_used_i && (issue_rs1_i == ent_rd[i])) raw_hit = 1'b1;
        if (issue_rs2_used_i && (issue_rs2_i == ent_rd[i])) raw_hit = 1'b1;
        if (issue_rd_used_i  && (issue_rd_i  == ent_rd[i])) waw_hit = 1'b1;
      end
    end
  end

  assign struct_hit = issue_is_load_i && (count == FULL_CNT);

  // Outputs are forced low while reset is held so nothing issues mid-reset.
  assign stall_o       = !rst_i && issue_valid_i && (raw_hit || waw_hit || struct_hit);
  assign issue_fire_o  = !rst_i && issue_valid_i && !stall_o;
  assign pending_cnt_o = count;
  assign underflow_o   = underflow;

  // A push can never happen while full (structural stall) and a pop never
  // while empty, so push and pop never target the same slot in one cycle.
  assign push          = issue_fire_o && issue_is_load_i;
  assign pop           = lsu_done_i && (count != 3'd0);
  assign underflow_evt = lsu_done_i && (count == 3'd0);

  // NOTE: the entry array is reset along with the pointers; it is only a few
  // flops, and a clean array keeps stale rd values out of the hazard compare.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < LOAD_DEPTH; i++) ent_rd[i] <= 5'd0;
      ent_vld   <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= 3'd0;
      underflow <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every flop sees
      // the pre-edge values, independent of statement order in this block.
      if (pop) begin
        for (int i = 0; i < LOAD_DEPTH; i++) begin
          if (PTR_W'(i) == rd_ptr) ent_vld[i] <= 1'b0;
        end
        rd_ptr <= next_ptr(rd_ptr);
      end

      // rd == 0 is pushed too, so later completions still line up.
      if (push) begin
        for (int i = 0; i < LOAD_DEPTH; i++) begin
          if (PTR_W'(i) == wr_ptr) begin
            ent_vld[i] <= 1'b1;
            ent_rd[i]  <= issue_rd_i;
          end
        end
        wr_ptr <= next_ptr(wr_ptr);
      end

      unique case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase

      if (underflow_evt) underflow <= 1'b1;
    end
  end

endmodule
